// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte sources onto a single UART transmitter (IDLE -> SEND -> WAIT).
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   win;
    logic              any_req;
    logic [DATA_W-1:0] win_data;

    assign any_req  = |req_valid;
    assign win_data = req_data[int'(win)*DATA_W +: DATA_W];

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr;

    // Scan downward so the requester closest after ptr is assigned last and wins.
    always_comb begin
        win = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % N_REQ])
                win = ID_W'((int'(ptr) + k) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= ID_W'(N_REQ - 1);
        else if (state == IDLE && any_req)
            ptr <= win;
    end
`else
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i])
                win = ID_W'(i);
        end
    end
`endif

    // Handshake and pulses are combinational to meet accept(n) -> tx_start(n+1); rst masks them.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_req && !rst)
            req_ready[win] = 1'b1;
    end

    assign tx_start    = (state == SEND) && !tx_busy && !rst;
    assign timeout_err = (state == WAIT) && !tx_done && (cnt == CNT_MAX) && !rst;
    assign busy        = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            grant_id <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        tx_data  <= win_data;
                        grant_id <= win;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done || cnt == CNT_MAX)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (TIMEOUT=16); grant-order expectations follow UART_ARB_ROUND_ROBIN_EN.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; tx_busy = 1'b0; tx_done = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, 8'(8'hE0 + i));
        cyc(); cyc(); #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        req_valid = '0; rst = 1'b0;
        cyc(); cyc(); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        exp_t e;
        set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'hA5); set_data(3, 8'h44);
        req_valid = 4'b0100; #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        sbq.push_back('{2'd2, 8'hA5});
        cyc(); req_valid = '0; #1;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", tx_start); end
        e = sbq.pop_front();
        checks++; if (tx_data !== e.data) begin errors++; $display("FAIL single_data got %h want %h", tx_data, e.data); end
        checks++; if (grant_id !== e.id) begin errors++; $display("FAIL single_grant got %0d want %0d", grant_id, e.id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        req_valid = 4'b0001; cyc(); #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_once got %b want 0", tx_start); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wait_ready got %b want 0000", req_ready); end
        req_valid = '0;
        tx_done = 1'b1; cyc(); tx_done = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_idle got %b want 0", busy); end
    endtask

    task automatic test_all_req();
        exp_t e;
        bit   found;
        int   ids[5];
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
`ifdef UART_ARB_ROUND_ROBIN_EN
        ids = '{0, 1, 2, 3, 0};
`else
        ids = '{0, 0, 0, 0, 0};
`endif
        for (int g = 0; g < 5; g++) sbq.push_back('{2'(ids[g]), 8'(8'h10 + ids[g])});
        req_valid = '1; #1;
        for (int g = 0; g < 5; g++) begin
            wait_start(8, found);
            e = sbq.pop_front();
            checks++;
            if (!found) begin
                errors++; $display("FAIL all_req_start grant %0d got none want tx_start", g);
            end else begin
                if (grant_id !== e.id || tx_data !== e.data) begin
                    errors++;
                    $display("FAIL all_req_grant %0d got id %0d data %h want id %0d data %h", g, grant_id, tx_data, e.id, e.data);
                end
            end
            if (g == 4) req_valid = '0;
            repeat (5) cyc();
            if (g < 4) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL all_req_wait_ready got %b want 0000", req_ready); end
            end
            repeat (5) cyc();
            tx_done = 1'b1; cyc(); tx_done = 1'b0; #1;
        end
        checks++; if (sbq.size() != 0) begin errors++; $display("FAIL all_req_sb_left got %0d want 0", sbq.size()); end
    endtask

    task automatic test_busy_tx();
        exp_t e;
        int   pulses = 0;
        set_data(0, 8'h3C);
        req_valid = 4'b0001; tx_busy = 1'b0; #1;
        sbq.push_back('{2'd0, 8'h3C});
        cyc(); req_valid = '0; tx_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tx_done = (k == 3);
            #1;
            if (tx_start === 1'b1) pulses++;
            cyc();
        end
        tx_done = 1'b0; tx_busy = 1'b0; #1;
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL busy_start_delayed got %b want 1", tx_start); end
        if (tx_start === 1'b1) pulses++;
        e = sbq.pop_front();
        checks++; if (tx_data !== e.data || grant_id !== e.id) begin errors++; $display("FAIL busy_data got %h/%0d want %h/%0d", tx_data, grant_id, e.data, e.id); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (tx_start === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulse_count got %0d want 1", pulses); end
        tx_done = 1'b1; cyc(); tx_done = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_done_idle got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   found;
        int   at = -1;
        set_data(3, 8'h77);
        req_valid = 4'b1000; #1;
        sbq.push_back('{2'd3, 8'h77});
        wait_start(4, found);
        req_valid = '0;
        e = sbq.pop_front();
        checks++; if (!found || tx_data !== e.data || grant_id !== e.id) begin errors++; $display("FAIL timeout_start got found %0d %h/%0d want 1 %h/%0d", found, tx_data, grant_id, e.data, e.id); end
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (timeout_err === 1'b1) begin at = k; break; end
        end
        checks++; if (at != TO) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", at, TO); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_at_err got %b want 1", busy); end
        cyc();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse got %b want 0", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b want 0", busy); end
    endtask

    task automatic test_done_at_limit();
        exp_t e;
        bit   found;
        int   errs = 0;
        set_data(1, 8'h5A);
        req_valid = 4'b0010; #1;
        sbq.push_back('{2'd1, 8'h5A});
        wait_start(4, found);
        req_valid = '0;
        e = sbq.pop_front();
        checks++; if (!found || tx_data !== e.data || grant_id !== e.id) begin errors++; $display("FAIL limit_start got found %0d %h/%0d want 1 %h/%0d", found, tx_data, grant_id, e.data, e.id); end
        for (int k = 1; k <= TO - 1; k++) begin
            cyc();
            if (timeout_err === 1'b1) errs++;
        end
        cyc(); tx_done = 1'b1; #1;
        if (timeout_err === 1'b1) errs++;
        checks++; if (errs != 0) begin errors++; $display("FAIL limit_done_wins got %0d err pulses want 0", errs); end
        cyc(); tx_done = 1'b0; #1;
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL limit_idle got busy %b err %b want 0 0", busy, timeout_err); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   found;
        int   pulses = 0;
        set_data(1, 8'hC3);
        req_valid = 4'b0010; #1;
        sbq.push_back('{2'd1, 8'hC3});
        wait_start(4, found);
        req_valid = '0;
        e = sbq.pop_front();
        checks++; if (!found || tx_data !== e.data) begin errors++; $display("FAIL rstmid_start got found %0d %h want 1 %h", found, tx_data, e.data); end
        cyc(); cyc();
        rst = 1'b1; req_valid = '1; #1;
        checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_during got ready %b busy %b want 0000 0", req_ready, busy); end
        cyc();
        rst = 1'b0; req_valid = 4'b0010; #1;
        checks++; if (tx_start !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_after got start %b err %b want 0 0", tx_start, timeout_err); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_ready got %b want 0010", req_ready); end
        sbq.push_back('{2'd1, 8'hC3});
        wait_start(4, found);
        e = sbq.pop_front();
        checks++; if (!found || tx_data !== e.data || grant_id !== e.id) begin errors++; $display("FAIL rstmid_regrant got found %0d %h/%0d want 1 %h/%0d", found, tx_data, grant_id, e.data, e.id); end
        // Reset landing in SEND must swallow the start pulse.
        rst = 1'b1; req_valid = '0; #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_in_send_start got %b want 0", tx_start); end
        cyc(); rst = 1'b0; #1;
        for (int k = 0; k < 2 * TO; k++) begin
            if (tx_start === 1'b1 || timeout_err === 1'b1 || busy === 1'b1) pulses++;
            cyc();
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_in_send_quiet got %0d active cycles want 0", pulses); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_busy_tx();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 The block SHALL have parameter DATA_W, default 8: byte width sent to the UART transmitter.
REQ-003 The block SHALL have parameter TIMEOUT, default 1_000_000: clk cycles allowed between tx_start and tx_done.
REQ-004 The block SHALL have port clk, input, 1: single clock, 50 MHz domain; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, N_REQ: per-requester byte available.
REQ-007 The block SHALL have port req_data, input, N_REQ*DATA_W: requester i byte in bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_ready, output, N_REQ: per-requester accept, one-hot or zero.
REQ-009 The block SHALL have port tx_start, output, 1: one-cycle start pulse to the UART transmitter.
REQ-010 The block SHALL have port tx_data, output, DATA_W: registered byte, stable from tx_start until return to IDLE.
REQ-011 The block SHALL have port tx_busy, input, 1: transmitter is shifting.
REQ-012 The block SHALL have port tx_done, input, 1: one-cycle pulse at the end of the stop bit.
REQ-013 The block SHALL have port grant_id, output, $clog2(N_REQ): index of the last accepted requester.
REQ-014 The block SHALL have port busy, output, 1: high in any state except IDLE.
REQ-015 The block SHALL have port timeout_err, output, 1: one-cycle pulse when a transfer is abandoned.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND and WAIT.
REQ-017 In IDLE with any req_valid high, the block SHALL combinationally assert req_ready for the arbitration winner only.
- The handshake completes in that same cycle.
- On the next edge: tx_data <= winner byte, grant_id <= winner, state -> SEND.
REQ-018 In IDLE with no req_valid, req_ready SHALL be all zero and the state SHALL stay IDLE.
REQ-019 req_ready SHALL be zero in SEND and WAIT regardless of req_valid.
REQ-020 In SEND, tx_start SHALL be high for exactly one cycle, the first SEND cycle in which tx_busy is 0, followed by state -> WAIT and the timeout counter cleared.
- While tx_busy is 1, the block SHALL stay in SEND with tx_start low.
REQ-021 Minimum latency SHALL be: accept at cycle n, tx_start at cycle n+1.
REQ-022 In WAIT, the counter SHALL increment each cycle.
- tx_done=1 -> IDLE; a new accept is possible in the following cycle.
REQ-023 If the counter reaches TIMEOUT-1 without tx_done, the block SHALL pulse timeout_err for one cycle and go to IDLE.
- If tx_done and timeout coincide, tx_done SHALL win and no error is flagged.
REQ-024 A tx_done pulse in IDLE or SEND SHALL be ignored.
REQ-025 A requester SHALL NOT drop req_valid before acceptance; the block SHALL NOT depend on this.
- Arbitration is re-evaluated every IDLE cycle.
REQ-026 The counter width SHALL be $clog2(TIMEOUT) and SHALL never wrap.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set:
- state=IDLE; tx_start=0; tx_data=0; grant_id=0.
- timeout_err=0; counter=0; round-robin pointer=N_REQ-1.
REQ-028 During rst, req_ready and busy SHALL be 0.
REQ-029 Reset in SEND or WAIT SHALL abandon the transfer without a tx_start or timeout_err pulse.

Configuration
REQ-030 The macro UART_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: round-robin. The search starts at pointer+1 mod N_REQ, and the pointer is updated to the winner on accept.
- Undefined: fixed priority, lowest index wins. The pointer logic is not compiled.

Verification
REQ-031 The bench SHALL cover the single-requester directed case.
- Stimulus: rst, then req_valid=4'b0100, req_data[2]=8'hA5, tx_busy=0.
- Response: req_ready=4'b0100 in the same cycle, tx_start and tx_data=8'hA5 next cycle, grant_id=2.
REQ-032 The bench SHALL cover the all-requesters, round-robin case.
- Stimulus: req_valid=4'b1111 held, macro defined, tx_done pulsed 10 cycles after each tx_start.
- Response: grant order 0,1,2,3,0.
REQ-033 The bench SHALL cover the same stimulus with the macro undefined.
- Response: every grant goes to 0.
REQ-034 The bench SHALL cover a busy transmitter.
- Stimulus: tx_busy=1 for 5 cycles after accept.
- Response: tx_start is delayed to the first cycle with tx_busy=0, and exactly one pulse is issued.
REQ-035 The bench SHALL cover timeout.
- Stimulus: TIMEOUT=16, no tx_done.
- Response: timeout_err pulses 16 cycles after tx_start, then IDLE, with busy=0.
REQ-036 The bench SHALL cover reset mid-operation.
- Stimulus: rst asserted in WAIT.
- Response: next cycle IDLE, tx_start=0, timeout_err=0, req_ready usable again after rst is released.
